// File: rtl/ctrl_pkg.sv
// Shared types for the RV32I(+M) pipeline control unit: opcodes, control enums,
// the per-stage control bundle and small decode helpers.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,  ALU_SLT  = 4'd5,  ALU_SLTU = 4'd6,  ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,  ALU_SRA  = 4'd9,  ALU_MUL  = 4'd10, ALU_MULH = 4'd11,
        ALU_DIV  = 4'd12, ALU_REM  = 4'd13
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_IMM = 2'b11
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
    } imm_src_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        jalr;
        logic        branch;
        logic        alu_src;
        alu_ctrl_e   alu_ctrl;
        logic        md;
        logic [2:0]  funct3;
    } ctrl_bundle_t;

    // Base-ISA ALU op selected by funct3 (funct7 alternates handled by the caller).
    function automatic alu_ctrl_e base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic lt, input logic ltu);
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = !z;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = !lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = !ltu;
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of opcode/funct3/funct7 into a control bundle and immediate format.
// Unsupported encodings produce an all-zero bundle with illegal raised.
import ctrl_pkg::*;

module ctrl_decode #(
    parameter int EN_MEXT = 1
) (
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output ctrl_bundle_t ctrl,
    output imm_src_e     imm_src,
    output logic         illegal
);

    ctrl_bundle_t c_s;
    imm_src_e     imm_s;
    logic         ill_s;

    // Per-opcode decode; anything not listed is illegal.
    always_comb begin
        c_s   = '0;
        imm_s = IMM_I;
        ill_s = 1'b0;
        case (op)
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    c_s.reg_write  = 1'b1;
                    c_s.result_src = RES_MEM;
                    c_s.alu_src    = 1'b1;
                end else begin
                    ill_s = 1'b1;
                end
            end
            OP_STORE: begin
                imm_s = IMM_S;
                if (funct3 == 3'b010) begin
                    c_s.mem_write = 1'b1;
                    c_s.alu_src   = 1'b1;
                end else begin
                    ill_s = 1'b1;
                end
            end
            OP_R: begin
                c_s.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    c_s.alu_ctrl = base_alu(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    c_s.alu_ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    c_s.alu_ctrl = ALU_SRA;
                end else if (EN_MEXT == 1 && funct7 == F7_MEXT) begin
                    c_s.md = 1'b1;
                    case (funct3)
                        3'b000:  c_s.alu_ctrl = ALU_MUL;
                        3'b001:  c_s.alu_ctrl = ALU_MULH;
                        3'b100:  c_s.alu_ctrl = ALU_DIV;
                        3'b110:  c_s.alu_ctrl = ALU_REM;
                        default: ill_s = 1'b1;
                    endcase
                end else begin
                    ill_s = 1'b1;
                end
            end
            OP_IMM: begin
                c_s.reg_write = 1'b1;
                c_s.alu_src   = 1'b1;
                // Shift-immediates reuse funct7 as a qualifier; other funct3 ignore it.
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    ill_s = 1'b1;
                end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                    c_s.alu_ctrl = ALU_SRA;
                end else if (funct3 == 3'b101 && funct7 != F7_BASE) begin
                    ill_s = 1'b1;
                end else begin
                    c_s.alu_ctrl = base_alu(funct3);
                end
            end
            OP_BRANCH: begin
                imm_s        = IMM_B;
                c_s.alu_ctrl = ALU_SUB;
                if (funct3[2:1] == 2'b01) begin
                    ill_s = 1'b1;
                end else begin
                    c_s.branch = 1'b1;
                end
            end
            OP_JAL: begin
                imm_s          = IMM_J;
                c_s.reg_write  = 1'b1;
                c_s.result_src = RES_PC4;
                c_s.jump       = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    c_s.reg_write  = 1'b1;
                    c_s.result_src = RES_PC4;
                    c_s.jump       = 1'b1;
                    c_s.jalr       = 1'b1;
                    c_s.alu_src    = 1'b1;
                end else begin
                    ill_s = 1'b1;
                end
            end
            OP_LUI: begin
                imm_s          = IMM_U;
                c_s.reg_write  = 1'b1;
                c_s.result_src = RES_IMM;
            end
            default: ill_s = 1'b1;
        endcase
        if (ill_s) begin
            c_s   = '0;
            imm_s = IMM_I;
        end else begin
            c_s.funct3 = funct3;
        end
    end

    assign ctrl    = c_s;
    assign imm_src = imm_s;
    assign illegal = ill_s;

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit: decodes in D, carries the control bundle through D/E, E/M, M/W,
// resolves branches/jumps in E and stalls the front of the pipe while a mul/div occupies E.
import ctrl_pkg::*;

module pipe_controller #(
    parameter int EN_MEXT    = 1,
    parameter int MD_LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opD,
    input  logic [2:0] funct3D,
    input  logic [6:0] funct7D,
    input  logic       FlushE,
    input  logic       ZeroE,
    input  logic       LtE,
    input  logic       LtuE,
    output logic [2:0] ImmSrcD,
    output logic       IllegalD,
    output logic       ALUSrcE,
    output logic [3:0] ALUControlE,
    output logic       MdE,
    output logic       PCSrcE,
    output logic       JalrE,
    output logic       ResultSrcE0,
    output logic       RegWriteM,
    output logic       MemWriteM,
    output logic       RegWriteW,
    output logic [1:0] ResultSrcW,
    output logic       StallMD
);

    localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_bundle_t     dec_s;
    imm_src_e         imm_src_s;
    logic             illegal_s;
    ctrl_bundle_t     de_d, de_q, em_d, em_q, mw_d, mw_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             stall_s, pcsrc_s;
    logic             unused_s;

    ctrl_decode #(.EN_MEXT(EN_MEXT)) u_decode (
        .op      (opD),
        .funct3  (funct3D),
        .funct7  (funct7D),
        .ctrl    (dec_s),
        .imm_src (imm_src_s),
        .illegal (illegal_s)
    );

    // The counter reaches MD_LAST on the op's final cycle in E, releasing the stall.
    assign stall_s = de_q.md && (cnt_q != MD_LAST);
    assign pcsrc_s = !stall_s && (de_q.jump ||
                     (de_q.branch && branch_taken(de_q.funct3, ZeroE, LtE, LtuE)));

    // Next-state for the stage registers and the mul/div occupancy counter.
    always_comb begin
        de_d  = de_q;
        em_d  = de_q;
        mw_d  = em_q;
        cnt_d = '0;
        if (stall_s) begin
            de_d = de_q;
            em_d = '0;
        end else if (FlushE) begin
            de_d = '0;
            em_d = de_q;
        end else begin
            de_d = dec_s;
            em_d = de_q;
        end
        if (de_q.md && stall_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = '0;
        end
    end

    // Stage registers; reset loads bubbles everywhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_q  <= '0;
            em_q  <= '0;
            mw_q  <= '0;
            cnt_q <= '0;
        end else begin
            de_q  <= de_d;
            em_q  <= em_d;
            mw_q  <= mw_d;
            cnt_q <= cnt_d;
        end
    end

    // D-stage decode outputs are held low while the unit is in reset.
    assign ImmSrcD     = reset ? imm_src_s : 3'b000;
    assign IllegalD    = reset ? illegal_s : 1'b0;
    assign ALUSrcE     = de_q.alu_src;
    assign ALUControlE = de_q.alu_ctrl;
    assign MdE         = de_q.md;
    assign PCSrcE      = pcsrc_s;
    assign JalrE       = de_q.jalr;
    assign ResultSrcE0 = de_q.result_src[0];
    assign RegWriteM   = em_q.reg_write;
    assign MemWriteM   = em_q.mem_write;
    assign RegWriteW   = mw_q.reg_write;
    assign ResultSrcW  = mw_q.result_src;
    assign StallMD     = stall_s;

    assign unused_s = ^{em_q, mw_q};

endmodule
